feature_weight_loader: RTL
==========================

Name: feature_weight_loader

Overview:
Upstream loader for the feature-weight memory. It accepts a serial stream of signed kernel weights over a valid/ready handshake and assembles each run of KERNEL_SIZE*KERNEL_SIZE weights into one flattened vector. For each completed vector it issues a single-cycle, active-low write strobe with the feature address. After NUM_FEATURES vectors it flags completion so the CNN controller can start convolution.

Parameters:
KERNEL_SIZE, 4, kernel edge length; each vector holds KERNEL_SIZE*KERNEL_SIZE weights.
NUM_FEATURES, 3, number of feature vectors per load; legal range is 1..4 because address_w is 2 bits.
DATA_WIDTH, 8, signed weight width.

Ports:
clk  input  1  main chip clock; all state updates on its rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  begins a load sequence when sampled high in IDLE.
weight_in  input  signed DATA_WIDTH  serial weight, row-major order (element 0 first).
weight_valid  input  1  weight_in is valid this cycle.
weight_ready  output  1  loader accepts a weight this cycle.
feature_weights_out  output  signed DATA_WIDTH x [KERNEL_SIZE*KERNEL_SIZE]  assembled vector, goes to the memory's weight input.
address_w  output  2  target feature index.
feature_WrEn  output  1  active-low write strobe.
busy  output  1  high whenever state is not IDLE.
load_done  output  1  sticky completion flag.

Behaviour:
- Reset (rst low at a rising edge), taking priority over everything, including mid-operation:
  - state = IDLE; element and feature counters = 0.
  - weight_ready = 0, feature_WrEn = 1, address_w = 0, busy = 0, load_done = 0.
  - every feature_weights_out element = 0.
  - No write strobe is ever emitted as a result of reset.
- All outputs are registered except weight_ready and busy, which decode directly from state.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - weight_ready = 0.
  - start = 1 -> LOAD. On that transition: elem_cnt = 0, feat_cnt = 0, load_done cleared.
- LOAD:
  - weight_ready = 1.
  - A beat is accepted when weight_valid && weight_ready. On acceptance: feature_weights_out[elem_cnt] <= weight_in, elem_cnt++.
  - Gaps in weight_valid simply stall the state; no timeout.
  - When the accepted beat is element KERNEL_SIZE*KERNEL_SIZE-1 -> WRITE. On the same edge: feature_WrEn <= 0, address_w <= feat_cnt.
- WRITE (exactly one cycle):
  - weight_ready = 0; feature_WrEn is low for this cycle only; feature_weights_out and address_w are held stable all cycle.
  - Timing: the memory samples on the falling edge mid-cycle, so the data is captured. Last beat accepted at edge N -> strobe low from edge N to edge N+1 (latency 1 cycle).
  - Exit: feature_WrEn <= 1.
    - If feat_cnt == NUM_FEATURES-1 -> DONE.
    - Else feat_cnt++, elem_cnt = 0 -> LOAD.
  - feature_weights_out is not cleared between features; elements are overwritten as new beats arrive.
- DONE:
  - Sets load_done <= 1 and goes to IDLE on the next edge.
  - load_done stays high until the next accepted start.
- start is ignored in LOAD, WRITE and DONE.
- start high in IDLE while load_done = 1 restarts the sequence and clears load_done.
- Counter widths: elem_cnt is $clog2(KERNEL_SIZE*KERNEL_SIZE)+1 bits; feat_cnt is 2 bits. No wrap occurs in legal operation.
- Stream ownership: weight_valid asserted outside LOAD is not consumed. The producer holds weight_in until ready is seen.

Test Plan:
1. Reset → idle values: apply rst=0 for 2 cycles with weight_valid=1 -> all outputs at reset values; feature_WrEn=1 throughout; weight_ready=0.
2. Full load with defaults: start, then 48 back-to-back beats with values 1..48 -> exactly three strobes.
   - Strobe for address 0 one cycle after beat 16, with out[0]=1 and out[15]=16.
   - Strobe for address 1 carries 17..32; strobe for address 2 carries 33..48.
   - load_done rises 2 cycles after the last strobe cycle; busy then returns to 0.
3. Gapped valid: random 0–3 idle cycles between beats, weights include -128 and 127 -> same three strobes with sign preserved; feature_WrEn never low more than 1 cycle.
4. Ignored start: pulse start during beat 5 of feature 1 -> no restart; counters continue; still exactly 3 strobes.
5. Reset mid-load: rst=0 after beat 20 -> no strobe for address 1; returns to IDLE. A fresh start then reloads 48 beats correctly.
6. Re-arm: start while load_done=1 with NUM_FEATURES=1, KERNEL_SIZE=3 -> load_done clears on the start edge; a single strobe at address 0 follows 9 beats, then load_done sets again.

Source files
------------

// File: rtl/feature_weight_loader.sv
// feature_weight_loader: packs a serial signed weight stream into kernel
// vectors, strobes each into feature memory, flags done after the last one.
module feature_weight_loader #(
  parameter int KERNEL_SIZE  = 4,
  parameter int NUM_FEATURES = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  input  logic                         weight_valid,
  output logic                         weight_ready,
  output logic signed [DATA_WIDTH-1:0] feature_weights_out [KERNEL_SIZE*KERNEL_SIZE],
  output logic [1:0]                   address_w,
  output logic                         feature_WrEn,
  output logic                         busy,
  output logic                         load_done
);

  localparam int NE = KERNEL_SIZE * KERNEL_SIZE;
  localparam int EW = $clog2(NE) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [EW-1:0] LAST_ELEM = EW'(NE - 1);
  localparam logic [1:0]    LAST_FEAT = 2'(NUM_FEATURES - 1);

  logic [1:0]    state;
  logic [EW-1:0] elem_cnt;
  logic [1:0]    feat_cnt;

  assign weight_ready = (state == S_LOAD);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      elem_cnt     <= '0;
      feat_cnt     <= '0;
      address_w    <= '0;
      feature_WrEn <= 1'b1;
      load_done    <= 1'b0;
      for (int i = 0; i < NE; i++)
        feature_weights_out[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            elem_cnt  <= '0;
            feat_cnt  <= '0;
            load_done <= 1'b0;
          end
        end
        S_LOAD: begin
          if (weight_valid) begin
            feature_weights_out[elem_cnt[EW-2:0]] <= weight_in;
            elem_cnt <= elem_cnt + 1'b1;
            // last beat: strobe goes low on this same edge
            if (elem_cnt == LAST_ELEM) begin
              state        <= S_WRITE;
              feature_WrEn <= 1'b0;
              address_w    <= feat_cnt;
            end
          end
        end
        S_WRITE: begin
          feature_WrEn <= 1'b1;
          if (feat_cnt == LAST_FEAT) begin
            state <= S_DONE;
          end else begin
            state    <= S_LOAD;
            feat_cnt <= feat_cnt + 1'b1;
            elem_cnt <= '0;
          end
        end
        S_DONE: begin
          load_done <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
